// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
// STOPWATCH_COUNTDOWN_EN (when defined) enables the countdown/load feature in dependent files.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      PAUSED  = 2'd1,
      ADJ_MIN = 2'd2,
      ADJ_SEC = 2'd3
   } state_t;

   localparam int unsigned DIGIT_W  = 4;
   localparam int unsigned SEC0_MOD = 10;
   localparam int unsigned SEC1_MOD = 6;
   localparam int unsigned MIN0_MOD = 10;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single modulo-MOD BCD digit with clear, load (clamped), increment and optional decrement.
// STOPWATCH_COUNTDOWN_EN adds the dec input.
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MOD = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inc,
`ifdef STOPWATCH_COUNTDOWN_EN
   input  logic               dec,
`endif
   input  logic               clr,
   input  logic               ld,
   input  logic [DIGIT_W-1:0] ld_val,
   output logic [DIGIT_W-1:0] q,
   output logic               tc_up,
   output logic               tc_dn
);

   localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(MOD - 1);

   logic [DIGIT_W-1:0] r_q;
   logic [DIGIT_W-1:0] w_q_nxt;

   // Priority: clear, then load, then count.
   always_comb begin
      w_q_nxt = r_q;
      if (clr) begin
         w_q_nxt = '0;
      end else if (ld) begin
         w_q_nxt = (ld_val > MAX) ? MAX : ld_val;
      end else if (inc) begin
         w_q_nxt = (r_q == MAX) ? '0 : r_q + DIGIT_W'(1);
`ifdef STOPWATCH_COUNTDOWN_EN
      end else if (dec) begin
         w_q_nxt = (r_q == '0) ? MAX : r_q - DIGIT_W'(1);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else begin
         r_q <= w_q_nxt;
      end
   end

   assign q     = r_q;
   assign tc_up = (r_q == MAX);
   assign tc_dn = (r_q == '0);

endmodule

// File: rtl/stopwatch_timer_core.sv
// MM:SS stopwatch core: mode FSM, digit carry chain and rollover pulse.
// STOPWATCH_COUNTDOWN_EN adds count_down/load/load_val/expired.
module stopwatch_timer_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned MIN_HI_MOD = 6,
   parameter int unsigned SATURATE   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_norm,
   input  logic               tick_fast,
   input  logic               pause_tgl,
   input  logic               adj,
   input  logic               sel,
   input  logic               clear,
`ifdef STOPWATCH_COUNTDOWN_EN
   input  logic               count_down,
   input  logic               load,
   input  logic [15:0]        load_val,
   output logic               expired,
`endif
   output logic [DIGIT_W-1:0] min1,
   output logic [DIGIT_W-1:0] min0,
   output logic [DIGIT_W-1:0] sec1,
   output logic [DIGIT_W-1:0] sec0,
   output logic [1:0]         state,
   output logic               rollover
);

   state_t r_state;
   state_t w_state_nxt;
   logic   r_paused;
   logic   w_paused_nxt;
   logic   r_rollover;
   logic   w_rollover_nxt;

   logic [DIGIT_W-1:0] w_sec0, w_sec1, w_min0, w_min1;
   logic w_sec0_tc_up, w_sec1_tc_up, w_min0_tc_up, w_min1_tc_up;
   logic w_sec0_tc_dn, w_sec1_tc_dn, w_min0_tc_dn, w_min1_tc_dn;
   logic w_sec0_inc, w_sec1_inc, w_min0_inc, w_min1_inc;
   logic w_run_tick, w_adj_min_tick, w_adj_sec_tick;
   logic w_at_max, w_up_step, w_cd_mode;
   logic w_ld;
   logic [15:0] w_ld_val;

`ifdef STOPWATCH_COUNTDOWN_EN
   logic w_sec0_dec, w_sec1_dec, w_min0_dec, w_min1_dec;
   logic w_at_zero, w_one_left, w_dn_step;
   logic r_expired;
   logic w_expired_nxt;

   assign w_ld      = load;
   assign w_ld_val  = load_val;
   assign w_cd_mode = count_down;
`else
   logic w_unused;

   assign w_ld      = 1'b0;
   assign w_ld_val  = '0;
   assign w_cd_mode = 1'b0;
   assign w_unused  = ^{w_sec0_tc_dn, w_sec1_tc_dn, w_min0_tc_dn, w_min1_tc_dn};
`endif

   // Pause toggles are honoured in every state; adj overrides the paused/run choice.
   always_comb begin
      w_state_nxt  = r_state;
      w_paused_nxt = r_paused ^ pause_tgl;
      if (adj) begin
         w_state_nxt = sel ? ADJ_SEC : ADJ_MIN;
      end else begin
         w_state_nxt = w_paused_nxt ? PAUSED : RUN;
      end
   end

   always_comb begin
      w_run_tick     = (r_state == RUN) && tick_norm && !clear && !w_ld;
      w_adj_min_tick = (r_state == ADJ_MIN) && tick_fast;
      w_adj_sec_tick = (r_state == ADJ_SEC) && tick_fast;
      w_at_max       = w_sec0_tc_up && w_sec1_tc_up && w_min0_tc_up && w_min1_tc_up;
      w_up_step      = w_run_tick && !w_cd_mode && !((SATURATE != 0) && w_at_max);
      // Seconds never carry into minutes while adjusting seconds.
      w_sec0_inc     = w_up_step || w_adj_sec_tick;
      w_sec1_inc     = w_sec0_inc && w_sec0_tc_up;
      w_min0_inc     = (w_up_step && w_sec0_tc_up && w_sec1_tc_up) || w_adj_min_tick;
      w_min1_inc     = w_min0_inc && w_min0_tc_up;
      w_rollover_nxt = w_up_step && w_at_max;
   end

`ifdef STOPWATCH_COUNTDOWN_EN
   // Countdown stops at 00:00; the step that lands there, or any tick while there, expires.
   always_comb begin
      w_at_zero     = w_sec0_tc_dn && w_sec1_tc_dn && w_min0_tc_dn && w_min1_tc_dn;
      w_one_left    = w_min1_tc_dn && w_min0_tc_dn && w_sec1_tc_dn && (w_sec0 == DIGIT_W'(1));
      w_dn_step     = w_run_tick && count_down && !w_at_zero;
      w_sec0_dec    = w_dn_step;
      w_sec1_dec    = w_sec0_dec && w_sec0_tc_dn;
      w_min0_dec    = w_sec1_dec && w_sec1_tc_dn;
      w_min1_dec    = w_min0_dec && w_min0_tc_dn;
      w_expired_nxt = r_expired;
      if (clear || load) begin
         w_expired_nxt = 1'b0;
      end else if (w_run_tick && count_down && (w_at_zero || w_one_left)) begin
         w_expired_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_expired <= 1'b0;
      end else begin
         r_expired <= w_expired_nxt;
      end
   end

   assign expired = r_expired;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_paused   <= 1'b0;
         r_rollover <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_paused   <= w_paused_nxt;
         r_rollover <= w_rollover_nxt;
      end
   end

   bcd_digit_counter #(.MOD(SEC0_MOD)) u_sec0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (w_sec0_inc),
`ifdef STOPWATCH_COUNTDOWN_EN
      .dec    (w_sec0_dec),
`endif
      .clr    (clear),
      .ld     (w_ld),
      .ld_val (w_ld_val[3:0]),
      .q      (w_sec0),
      .tc_up  (w_sec0_tc_up),
      .tc_dn  (w_sec0_tc_dn)
   );

   bcd_digit_counter #(.MOD(SEC1_MOD)) u_sec1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (w_sec1_inc),
`ifdef STOPWATCH_COUNTDOWN_EN
      .dec    (w_sec1_dec),
`endif
      .clr    (clear),
      .ld     (w_ld),
      .ld_val (w_ld_val[7:4]),
      .q      (w_sec1),
      .tc_up  (w_sec1_tc_up),
      .tc_dn  (w_sec1_tc_dn)
   );

   bcd_digit_counter #(.MOD(MIN0_MOD)) u_min0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (w_min0_inc),
`ifdef STOPWATCH_COUNTDOWN_EN
      .dec    (w_min0_dec),
`endif
      .clr    (clear),
      .ld     (w_ld),
      .ld_val (w_ld_val[11:8]),
      .q      (w_min0),
      .tc_up  (w_min0_tc_up),
      .tc_dn  (w_min0_tc_dn)
   );

   bcd_digit_counter #(.MOD(MIN_HI_MOD)) u_min1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (w_min1_inc),
`ifdef STOPWATCH_COUNTDOWN_EN
      .dec    (w_min1_dec),
`endif
      .clr    (clear),
      .ld     (w_ld),
      .ld_val (w_ld_val[15:12]),
      .q      (w_min1),
      .tc_up  (w_min1_tc_up),
      .tc_dn  (w_min1_tc_dn)
   );

   assign sec0     = w_sec0;
   assign sec1     = w_sec1;
   assign min0     = w_min0;
   assign min1     = w_min1;
   assign state    = r_state;
   assign rollover = r_rollover;

endmodule

// File: doc/stopwatch_timer_core.md
# stopwatch_timer_core

Single-clock, parametrised MM:SS stopwatch core, the successor to the two-clock counter controller. Gated and muxed clocks are replaced by tick strobes, and the run, pause and adjust modes are decided by an internal state machine instead of raw enables. The core sits between the tick generator and the seven-segment display driver and produces four registered BCD digits plus status.

## Interface
Parameters:
- MIN_HI_MOD, default 6: modulus of the minute tens digit, legal range 2..10 (6 gives 59:59, 10 gives 99:59).
- SATURATE, default 0: 1 holds at the maximum value in up-count; 0 wraps to 00:00.

Ports:
- clk, input, 1: sole clock.
- rst_n, input, 1: asynchronous, active-low reset.
- tick_norm, input, 1: 1 Hz single-cycle strobe.
- tick_fast, input, 1: 2 Hz single-cycle strobe, used for adjust.
- pause_tgl, input, 1: single-cycle pulse that toggles the paused flag.
- adj, input, 1: level; 1 selects adjust mode.
- sel, input, 1: level, valid while adj=1; 0 adjusts minutes, 1 adjusts seconds.
- clear, input, 1: synchronous pulse that zeroes all digits.
- min1, min0, sec1, sec0, output, 4 each: BCD digits, registered.
- state, output, 2: current FSM state encoding.
- rollover, output, 1: one-cycle pulse on wrap from maximum to 00:00.

## Operation
- FSM states: RUN=0, PAUSED=1, ADJ_MIN=2, ADJ_SEC=3.
- Next state when adj=1: ADJ_MIN if sel=0, otherwise ADJ_SEC. The sel input is re-evaluated every cycle, so the adjust field can switch freely.
- Next state when adj=0: PAUSED if the paused flag is set after this cycle's update, otherwise RUN.
- Paused flag: pause_tgl flips it in every state, including the adjust states. A toggle made during adjust takes effect when adj falls.
- RUN: on tick_norm, sec0 increments.
  - sec0 9->0 carries into sec1.
  - sec1 5->0 carries into min0.
  - min0 9->0 carries into min1.
  - min1 wraps from MIN_HI_MOD-1 to 0.
- Full wrap at maximum (digits {MIN_HI_MOD-1, 9, 5, 9}):
  - SATURATE=0: all digits go to 0 and rollover pulses.
  - SATURATE=1: digits hold, no rollover pulse.
- PAUSED: digits hold; both ticks are ignored.
- ADJ_MIN: on tick_fast the minutes increment (min0 carries into min1, min1 wraps to 0 regardless of SATURATE). Seconds are frozen; no rollover pulse.
- ADJ_SEC: on tick_fast the seconds increment (sec0 carries into sec1, sec1 wraps 5->0 with no carry into minutes). Minutes are frozen.
- Ignored strobes: tick_fast in RUN; tick_norm in ADJ_*.
- clear: has priority over any tick in the same cycle. Zeroes digits only; state and paused flag are unchanged.

## Timing
- Reset values: all digits 0, state=RUN, paused flag 0, rollover 0.
- Latency: digits update on the clk edge that samples the strobe and are visible the following cycle. rollover is asserted in the same cycle the digits show 00:00.
- FSM: one-cycle latency from an adj, sel or pause_tgl change to the state output.
- Mode change and tick in the same cycle: the tick is evaluated against the state before the edge (the current registered state).
- Back-to-back strobes: each is counted; no minimum spacing is required.
- Reset asserted mid-count: immediate asynchronous return to reset values, no partial carry.

## Configuration
- STOPWATCH_COUNTDOWN_EN defined adds these ports:
  - count_down, input, 1: RUN decrements instead of increments.
  - load, input, 1: pulse that loads load_val.
  - load_val, input, 16: value as four BCD nibbles {min1, min0, sec1, sec0}.
  - expired, output, 1: level flag.
- Countdown rules:
  - In RUN with count_down=1, tick_norm decrements with borrow.
  - At 00:00 the core holds and sets expired; expired stays set until load or clear.
  - load has priority below clear and above any tick. Out-of-range nibbles are clamped to the digit maximum.
  - Adjust modes always increment.
- STOPWATCH_COUNTDOWN_EN undefined: these ports are absent, the core counts up only, and there is no other behavioural change.

## Structure
- Package stopwatch_pkg holds:
  - the state enum (RUN, PAUSED, ADJ_MIN, ADJ_SEC);
  - constants SEC0_MOD=10, SEC1_MOD=6, MIN0_MOD=10;
  - the BCD digit width (4).
- Sub-module bcd_digit_counter, one instance per digit:
  - parameter MOD;
  - inputs inc, dec (macro only), clr, ld/ld_val;
  - outputs q[3:0], tc_up (q==MOD-1), tc_dn (q==0).
- Carry enables, the FSM and rollover generation live in the top module.

## Test plan
- Reset, then 60 tick_norm in RUN -> digits 01:00, no rollover pulse.
- MIN_HI_MOD=6, SATURATE=0, preset to 59:59 via ADJ (or load), then tick_norm -> 00:00 and rollover high for exactly one cycle. Repeat with SATURATE=1 -> digits stay 59:59, no pulse.
- adj=1, sel=0, 12 tick_fast from 00:00 -> 12:00. Then sel=1, 65 tick_fast -> 12:05 (seconds wrap, minutes untouched). Interleaved tick_norm strobes cause no change.
- pause_tgl at 00:07, 10 tick_norm -> holds 00:07, state=PAUSED. A second pause_tgl resumes; clear together with tick_norm -> 00:00.
- rst_n asserted mid-carry at 09:59 with a tick in flight -> immediate 00:00, state RUN.
- With STOPWATCH_COUNTDOWN_EN: load 0x0102, count_down=1, 62 tick_norm -> 00:00 and expired=1. A further tick holds 00:00; load clears expired.
